ucode_mul_sequencer: RTL and testbench

//  Microcode multiply engine directly downstream of the instruction decoder.

---
 rtl/ucode_pkg.sv | 21 ++
 rtl/ucode_mul_sequencer_if.sv | 32 +++
 rtl/mul_shift_add_dp.sv | 62 ++++++
 rtl/ucode_mul_sequencer.sv | 91 +++++++++
 tb/tb_ucode_mul_sequencer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ucode_pkg.sv
// Shared definitions for the microcode multiply sequencer: default widths, FSM state
// encoding, operand-select codes and the decoder opcodes that raise a multiply request.
package ucode_pkg;

    localparam int unsigned MUL_DATA_W     = 32;
    localparam int unsigned MUL_REG_ADDR_W = 4;
    localparam int unsigned MUL_IMM_W      = 16;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_CALC = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    localparam logic MUL_TYPE_IMM = 1'b0;
    localparam logic MUL_TYPE_REG = 1'b1;

    localparam logic [6:0] OPC_MULR = 7'b0110000;
    localparam logic [6:0] OPC_MULI = 7'b0010000;

endpackage : ucode_pkg

// File: rtl/ucode_mul_sequencer_if.sv
// Decoder request / front-end stall / register-file write-back bundle of the multiply sequencer.
interface ucode_mul_sequencer_if
    import ucode_pkg::*;
#(
    parameter int unsigned DATA_W     = MUL_DATA_W,
    parameter int unsigned REG_ADDR_W = MUL_REG_ADDR_W,
    parameter int unsigned IMM_W      = MUL_IMM_W
);
    logic                  mul_trigger;
    logic                  mul_type;
    logic [REG_ADDR_W-1:0] dest_reg;
    logic [DATA_W-1:0]     src1_val;
    logic [DATA_W-1:0]     src2_val;
    logic [IMM_W-1:0]      imm;
    logic                  stall;
    logic                  busy;
    logic                  wb_valid;
    logic                  wb_ready;
    logic [REG_ADDR_W-1:0] wb_reg;
    logic [DATA_W-1:0]     wb_data;

    modport slave (
        input  mul_trigger, mul_type, dest_reg, src1_val, src2_val, imm, wb_ready,
        output stall, busy, wb_valid, wb_reg, wb_data
    );

    modport master (
        output mul_trigger, mul_type, dest_reg, src1_val, src2_val, imm, wb_ready,
        input  stall, busy, wb_valid, wb_reg, wb_data
    );

endinterface : ucode_mul_sequencer_if

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiply datapath: operand/accumulator/count registers stepped by the sequencer FSM.
// UCODE_MUL_EARLY_EXIT_EN: calc_last_c also fires once the remaining multiplier bits are all zero.
module mul_shift_add_dp
    import ucode_pkg::*;
#(
    parameter int unsigned DATA_W     = MUL_DATA_W,
    parameter int unsigned REG_ADDR_W = MUL_REG_ADDR_W,
    parameter int unsigned IMM_W      = MUL_IMM_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic                  mul_type,
    input  logic [REG_ADDR_W-1:0] dest_reg,
    input  logic [DATA_W-1:0]     src1_val,
    input  logic [DATA_W-1:0]     src2_val,
    input  logic [IMM_W-1:0]      imm,
    output logic [DATA_W-1:0]     acc,
    output logic [REG_ADDR_W-1:0] wb_reg,
    output logic                  calc_last_c
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] multiplicand;
    logic [DATA_W-1:0] multiplier;
    logic [CNT_W-1:0]  count;

    // One partial product per step; acc wraps modulo 2^DATA_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc          <= '0;
            multiplicand <= '0;
            multiplier   <= '0;
            count        <= '0;
            wb_reg       <= '0;
        end else if (load) begin
            acc          <= '0;
            multiplicand <= src1_val;
            multiplier   <= (mul_type == MUL_TYPE_REG) ? src2_val : DATA_W'(imm);
            count        <= '0;
            wb_reg       <= dest_reg;
        end else if (step) begin
            acc          <= acc + (multiplier[0] ? multiplicand : '0);
            multiplicand <= multiplicand << 1;
            multiplier   <= multiplier >> 1;
            count        <= count + CNT_W'(1);
        end
    end

    // Flags the step currently in progress as the final one.
    always_comb begin
        calc_last_c = (count == CNT_W'(DATA_W - 1));
`ifdef UCODE_MUL_EARLY_EXIT_EN
        if (multiplier[DATA_W-1:1] == '0) begin
            calc_last_c = 1'b1;
        end
`endif
    end

endmodule : mul_shift_add_dp

// File: rtl/ucode_mul_sequencer.sv
// Iterative multiply engine behind the decoder: stalls the front end, then hands one write-back
// to the register file. Build option UCODE_MUL_EARLY_EXIT_EN shortens CALC for small multipliers.
module ucode_mul_sequencer
    import ucode_pkg::*;
#(
    parameter int unsigned DATA_W     = MUL_DATA_W,
    parameter int unsigned REG_ADDR_W = MUL_REG_ADDR_W,
    parameter int unsigned IMM_W      = MUL_IMM_W
) (
    input  logic              clk,
    input  logic              rst,
    ucode_mul_sequencer_if.slave bus
);

    mul_state_e state;
    mul_state_e state_next;
    logic       load_c;
    logic       step_c;
    logic       calc_last_c;
    logic       busy_q;
    logic       wb_valid_q;

    logic [DATA_W-1:0]     acc;
    logic [REG_ADDR_W-1:0] wb_reg_q;

    mul_shift_add_dp #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .IMM_W      (IMM_W)
    ) u_dp (
        .clk         (clk),
        .rst         (rst),
        .load        (load_c),
        .step        (step_c),
        .mul_type    (bus.mul_type),
        .dest_reg    (bus.dest_reg),
        .src1_val    (bus.src1_val),
        .src2_val    (bus.src2_val),
        .imm         (bus.imm),
        .acc         (acc),
        .wb_reg      (wb_reg_q),
        .calc_last_c (calc_last_c)
    );

    // busy/wb_valid are registered copies of the next-state decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= MUL_IDLE;
            busy_q     <= 1'b0;
            wb_valid_q <= 1'b0;
        end else begin
            state      <= state_next;
            busy_q     <= (state_next != MUL_IDLE);
            wb_valid_q <= (state_next == MUL_DONE);
        end
    end

    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        step_c     = 1'b0;
        case (state)
            MUL_IDLE: begin
                if (bus.mul_trigger) begin
                    load_c     = 1'b1;
                    state_next = MUL_CALC;
                end
            end
            MUL_CALC: begin
                step_c = 1'b1;
                if (calc_last_c) begin
                    state_next = MUL_DONE;
                end
            end
            MUL_DONE: begin
                if (bus.wb_ready) begin
                    state_next = MUL_IDLE;
                end
            end
            default: state_next = MUL_IDLE;
        endcase
    end

    // The decoder must freeze in the very cycle it raises a request.
    assign bus.stall    = bus.mul_trigger | busy_q;
    assign bus.busy     = busy_q;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_reg   = wb_reg_q;
    assign bus.wb_data  = acc;

endmodule : ucode_mul_sequencer

// File: tb/tb_ucode_mul_sequencer.sv
// Randomized scoreboard bench for ucode_mul_sequencer; latency expectations follow
// UCODE_MUL_EARLY_EXIT_EN when the bench is built with it.
module tb_ucode_mul_sequencer;
    import ucode_pkg::*;

    localparam int unsigned DW = MUL_DATA_W;
    localparam int unsigned AW = MUL_REG_ADDR_W;
    localparam int unsigned IW = MUL_IMM_W;
    localparam int unsigned PW = 2 * DW;

    typedef struct {
        logic [AW-1:0] rg;
        logic [DW-1:0] data;
        int            lat;
        int            trig;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t expq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ucode_mul_sequencer_if bus ();

    ucode_mul_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain wide multiplication, keep the low DW bits.
    function automatic logic [DW-1:0] model_prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [PW-1:0] p;
        p = PW'(a) * PW'(b);
        return p[DW-1:0];
    endfunction

    function automatic int calc_cycles(input logic [DW-1:0] m);
`ifdef UCODE_MUL_EARLY_EXIT_EN
        int h = 0;
        for (int i = 0; i < int'(DW); i++) begin
            if (m[i]) h = i + 1;
        end
        return (h == 0) ? 1 : h;
`else
        return int'(DW);
`endif
    endfunction

    // Monitor: pops one expectation per write-back, then checks hold stability until the handshake.
    initial begin
        logic          in_done;
        logic [AW-1:0] h_reg;
        logic [DW-1:0] h_data;
        exp_t          e;
        in_done = 1'b0;
        h_reg   = '0;
        h_data  = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                in_done = 1'b0;
            end else if (bus.wb_valid === 1'b1) begin
                if (!in_done) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_wb_valid", 64'(expq.size()), 64'd1);
                    end else begin
                        e = expq.pop_front();
                        chk("wb_reg", 64'(bus.wb_reg), 64'(e.rg));
                        chk("wb_data", 64'(bus.wb_data), 64'(e.data));
                        chk("wb_latency", 64'(cyc - e.trig), 64'(e.lat));
                    end
                    h_reg   = bus.wb_reg;
                    h_data  = bus.wb_data;
                    in_done = 1'b1;
                end else begin
                    chk("wb_reg_stable", 64'(bus.wb_reg), 64'(h_reg));
                    chk("wb_data_stable", 64'(bus.wb_data), 64'(h_data));
                end
                if (bus.wb_ready === 1'b1) in_done = 1'b0;
            end
        end
    end

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic typ, input logic [AW-1:0] dest, input logic [DW-1:0] s1,
                         input logic [DW-1:0] s2, input logic [IW-1:0] im);
        exp_t          e;
        logic [DW-1:0] m;
        int            n;
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            step_cycle();
            n++;
        end
        m = typ ? s2 : DW'(im);
        bus.mul_type    = typ;
        bus.dest_reg    = dest;
        bus.src1_val    = s1;
        bus.src2_val    = s2;
        bus.imm         = im;
        bus.mul_trigger = 1'b1;
        e.rg   = dest;
        e.data = model_prod(s1, m);
        e.lat  = calc_cycles(m) + 1;
        e.trig = cyc;
        expq.push_back(e);
        #1;
        chk("stall_same_cycle", 64'(bus.stall), 64'd1);
        step_cycle();
        bus.mul_trigger = 1'b0;
        bus.src1_val    = $urandom;
        bus.src2_val    = $urandom;
        bus.imm         = IW'($urandom);
        bus.dest_reg    = AW'($urandom);
        bus.mul_type    = 1'($urandom);
        chk("busy_after_trigger", 64'(bus.busy), 64'd1);
    endtask

    task automatic do_mul(input logic typ, input logic [AW-1:0] dest, input logic [DW-1:0] s1,
                          input logic [DW-1:0] s2, input logic [IW-1:0] im,
                          input int rdy_dly, input bit spur);
        int n;
        issue(typ, dest, s1, s2, im);
        n = 0;
        while (bus.wb_valid !== 1'b1 && n < 100) begin
            if (spur) begin
                bus.mul_trigger = 1'($urandom);
                bus.wb_ready    = 1'($urandom);
            end
            step_cycle();
            n++;
        end
        bus.wb_ready = 1'b0;
        chk("wb_valid_reached", 64'(bus.wb_valid), 64'd1);
        for (int d = 0; d < rdy_dly; d++) begin
            if (spur) bus.mul_trigger = 1'($urandom);
            step_cycle();
        end
        bus.wb_ready = 1'b1;
        if (spur) bus.mul_trigger = 1'b1;
        step_cycle();
        bus.wb_ready    = 1'b0;
        bus.mul_trigger = 1'b0;
        chk("idle_after_handshake", 64'(bus.busy), 64'd0);
        chk("wb_valid_dropped", 64'(bus.wb_valid), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"}, 64'(bus.stall), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_wb_valid"}, 64'(bus.wb_valid), 64'd0);
        chk({tag, "_wb_reg"}, 64'(bus.wb_reg), 64'd0);
        chk({tag, "_wb_data"}, 64'(bus.wb_data), 64'd0);
    endtask

    task automatic reset_abort();
        exp_t e;
        bit   seen;
        issue(MUL_TYPE_REG, 4'd7, 32'h1234_5678, 32'h0000_00FF, 16'd0);
        for (int i = 0; i < 9; i++) step_cycle();
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        e = expq.pop_back();
        step_cycle();
        step_cycle();
        check_all_zero("held_reset");
        rst  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step_cycle();
            if (bus.wb_valid === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
        end
        chk("no_wb_after_abort", 64'(seen), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] s1;
        logic [DW-1:0] s2;
        rst             = 1'b0;
        bus.mul_trigger = 1'b0;
        bus.mul_type    = 1'b0;
        bus.dest_reg    = '0;
        bus.src1_val    = '0;
        bus.src2_val    = '0;
        bus.imm         = '0;
        bus.wb_ready    = 1'b0;
        step_cycle();
        step_cycle();
        check_all_zero("reset");
        rst = 1'b1;
        step_cycle();
        chk("idle_stall_low", 64'(bus.stall), 64'd0);

        do_mul(MUL_TYPE_IMM, 4'd3, 32'd7, 32'd0, 16'd6, 0, 1'b0);
        do_mul(MUL_TYPE_REG, 4'd5, 32'hFFFF_FFFF, 32'd2, 16'd0, 1, 1'b0);
        do_mul(MUL_TYPE_REG, 4'd9, 32'h0001_0000, 32'h0001_0000, 16'd0, 0, 1'b0);
        do_mul(MUL_TYPE_REG, 4'd2, 32'd123, 32'd456, 16'd0, 5, 1'b0);
        do_mul(MUL_TYPE_IMM, 4'd15, 32'hFFFF_FFFD, 32'd0, 16'hFFFF, 2, 1'b0);

        reset_abort();
        do_mul(MUL_TYPE_REG, 4'd1, 32'd1000, 32'd1000, 16'd0, 0, 1'b0);

        do_mul(MUL_TYPE_REG, 4'd6, 32'hDEAD_BEEF, 32'h0000_0013, 16'd0, 2, 1'b1);
        do_mul(MUL_TYPE_IMM, 4'd8, 32'h8000_0001, 32'd0, 16'h8001, 1, 1'b1);
        do_mul(MUL_TYPE_REG, 4'd10, 32'hFFFF_FFF9, 32'hFFFF_FFFB, 16'd0, 0, 1'b0);

        do_mul(MUL_TYPE_REG, 4'd4, 32'h0BAD_F00D, 32'd0, 16'd0, 0, 1'b0);
        do_mul(MUL_TYPE_REG, 4'd4, 32'h0BAD_F00D, 32'd5, 16'd0, 0, 1'b0);
        do_mul(MUL_TYPE_REG, 4'd11, 32'd3, 32'h8000_0000, 16'd0, 0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            s1 = $urandom;
            case ($urandom % 4)
                0:       s2 = DW'($urandom % 16);
                1:       s2 = '0;
                default: s2 = $urandom;
            endcase
            if ($urandom % 5 == 0) s1 = '1;
            do_mul(1'($urandom), AW'($urandom), s1, s2, IW'($urandom),
                   int'($urandom % 4), ($urandom % 4) == 0);
        end

        step_cycle();
        step_cycle();
        chk("scoreboard_drained", 64'(expq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ucode_mul_sequencer
